// File: rtl/ipad_debounce.sv
// Input pad receiver: synchronizes the raw pad level and accepts a level change only
// after FILTER_LEN consecutive equal samples, emitting one-cycle rise/fall pulses.
(* CLASS = "input" *)
module ipad_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inpad,
  input  logic en,
  output logic level,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic [1:0] {STABLE_LO, QUAL_HI, STABLE_HI, QUAL_LO} state_e;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, rise_q, fall_q;
  logic                   level_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], inpad};
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      STABLE_LO: if (en && s) begin
        if (FILTER_LEN == 1) state_d = STABLE_HI;
        else begin
          state_d = QUAL_HI;
          cnt_d   = CNT_ONE;
        end
      end
      QUAL_HI: begin
        // Disable or a single disagreeing sample drops back without a pulse.
        if (!en || !s) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: if (en && !s) begin
        if (FILTER_LEN == 1) state_d = STABLE_LO;
        else begin
          state_d = QUAL_LO;
          cnt_d   = CNT_ONE;
        end
      end
      QUAL_LO: begin
        if (!en || s) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_d = (state_d == STABLE_HI) || (state_d == QUAL_LO);

  // Pulses come from the level edge, so a QUAL_x revert never produces one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= level_d & ~level_q;
      fall_q  <= ~level_d & level_q;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign busy  = (state_q == QUAL_HI) || (state_q == QUAL_LO);

endmodule

// File: tb/tb_ipad_debounce.sv
// Scoreboard bench for ipad_debounce: per-cycle expected {level,rise,fall,busy} queued
// by the driver, popped and compared just after each rising edge.
module tb_ipad_debounce;

  logic clk, rst_n, inpad, en, inpad1;
  logic level, rise, fall, busy;
  logic level1, rise1, fall1, busy1;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    string      tag;
    logic [3:0] exp;
    bit         which;
  } exp_t;

  exp_t sb[$];

  ipad_debounce dut (
    .clk(clk), .rst_n(rst_n), .inpad(inpad), .en(en),
    .level(level), .rise(rise), .fall(fall), .busy(busy)
  );

  ipad_debounce #(.FILTER_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .inpad(inpad1), .en(1'b1),
    .level(level1), .rise(rise1), .fall(fall1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Drive inputs for the next edge and queue the outputs expected after it.
  task automatic drv(input logic ip, input logic e, input logic [3:0] ex, input string tag,
                     input bit which);
    exp_t t;
    @(negedge clk);
    if (which) inpad1 = ip;
    else begin
      inpad = ip;
      en    = e;
    end
    t.tag = tag; t.exp = ex; t.which = which;
    sb.push_back(t);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t t;
      t = sb.pop_front();
      if (t.which) chk(t.tag, {28'h0, level1, rise1, fall1, busy1}, {28'h0, t.exp});
      else         chk(t.tag, {28'h0, level, rise, fall, busy}, {28'h0, t.exp});
    end
  end

  // {level,rise,fall,busy} after each edge, edge 0 = first edge seeing the new inpad
  localparam logic [3:0] EA [8]  = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'hC, 4'h8, 4'h8};
  localparam logic [3:0] EB [7]  = '{4'h8, 4'h8, 4'h9, 4'h9, 4'h9, 4'h2, 4'h0};
  localparam logic [3:0] EC [7]  = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0};
  localparam logic [3:0] EE [5]  = '{4'h1, 4'h1, 4'h1, 4'hC, 4'h8};
  localparam logic       EN2[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam logic [3:0] EE2[10] = '{4'h8, 4'h8, 4'h9, 4'h8, 4'h8, 4'h9, 4'h9, 4'h9, 4'h2, 4'h0};
  localparam logic [3:0] EF [9]  = '{4'h0, 4'h0, 4'hC, 4'h8, 4'h8, 4'h8, 4'h8, 4'h2, 4'h0};

  initial begin
    rst_n = 1'b0; inpad = 1'b0; en = 1'b1; inpad1 = 1'b0;
    #2;
    chk("reset_out", {28'h0, level, rise, fall, busy}, 32'h0);
    chk("reset_out_f1", {28'h0, level1, rise1, fall1, busy1}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) drv(1'b1, 1'b1, EA[i], $sformatf("rise_e%0d", i), 1'b0);
    for (int i = 0; i < 7; i++) drv(1'b0, 1'b1, EB[i], $sformatf("fall_e%0d", i), 1'b0);
    for (int i = 0; i < 7; i++) drv(i < 3, 1'b1, EC[i], $sformatf("glitch_e%0d", i), 1'b0);

    // Reset during QUAL_HI with cnt=2
    drv(1'b1, 1'b1, 4'h0, "rstq_e0", 1'b0);
    drv(1'b1, 1'b1, 4'h0, "rstq_e1", 1'b0);
    drv(1'b1, 1'b1, 4'h1, "rstq_e2", 1'b0);
    drv(1'b1, 1'b1, 4'h1, "rstq_e3", 1'b0);
    @(negedge clk);
    rst_n = 1'b0; inpad = 1'b0;
    #1;
    chk("rst_async_level", {31'h0, level}, 32'h0);
    chk("rst_async_busy",  {31'h0, busy},  32'h0);
    chk("rst_async_pulse", {30'h0, rise, fall}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) drv(1'b0, 1'b1, 4'h0, $sformatf("rst_after_e%0d", i), 1'b0);

    // Disabled: sync runs, FSM stays put; then enable qualifies from scratch
    for (int i = 0; i < 10; i++) drv(1'b1, 1'b0, 4'h0, $sformatf("dis_e%0d", i), 1'b0);
    for (int i = 0; i < 5; i++) drv(1'b1, 1'b1, EE[i], $sformatf("en_rise_e%0d", i), 1'b0);
    for (int i = 0; i < 10; i++) drv(1'b0, EN2[i], EE2[i], $sformatf("en_revert_e%0d", i), 1'b0);

    // FILTER_LEN=1 instance
    for (int i = 0; i < 9; i++) drv(i < 5, 1'b1, EF[i], $sformatf("f1_e%0d", i), 1'b1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ipad_debounce.md
IPAD_DEBOUNCE -- requirements
Module: ipad_debounce

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on the pad input, legal range 2..4.
REQ-002 The block SHALL have parameter FILTER_LEN, default 4: number of consecutive equal synchronized samples required to accept a level change, legal range 1..255.
REQ-003 The block SHALL have parameter CNT_W, default 8: qualification counter width, with 2**CNT_W > FILTER_LEN.
REQ-004 The block SHALL have a port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-005 The block SHALL have a port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have a port inpad, input, 1 bit: raw, asynchronous pad level from the package pin.
REQ-007 The block SHALL have a port en, input, 1 bit: filter enable.
REQ-008 The block SHALL have a port level, output, 1 bit: debounced pad level.
REQ-009 The block SHALL have a port rise, output, 1 bit: single-cycle pulse when level goes 0->1.
REQ-010 The block SHALL have a port fall, output, 1 bit: single-cycle pulse when level goes 1->0.
REQ-011 The block SHALL have a port busy, output, 1 bit: high while a level change is being qualified.
REQ-012 The block SHALL carry attribute CLASS="input", making it the receive-side counterpart of the output pad cell.

Function
REQ-013 The block SHALL shift inpad through a SYNC_STAGES-deep flop chain, where s denotes the last stage.
REQ-014 The FSM SHALL have exactly four states: STABLE_LO, QUAL_HI, STABLE_HI, QUAL_LO.
REQ-015 In STABLE_LO with en=1 and s=1, the FSM SHALL go to QUAL_HI and set cnt=1; if FILTER_LEN=1, it SHALL go directly to STABLE_HI instead.
REQ-016 In QUAL_HI with s=0, the FSM SHALL return to STABLE_LO and clear cnt, with no pulse (glitch rejected).
REQ-017 In QUAL_HI with s=1 and cnt=FILTER_LEN-1, the FSM SHALL go to STABLE_HI and clear cnt; otherwise it SHALL increment cnt.
REQ-018 STABLE_HI and QUAL_LO SHALL be the exact mirror of REQ-015..REQ-017 with the polarity of s inverted.
REQ-019 level SHALL be 1 exactly in the STABLE_HI and QUAL_LO states, and SHALL be registered.
REQ-020 rise SHALL be high for exactly the one cycle following the entry into STABLE_HI, and fall for the one cycle following the entry into STABLE_LO; rise and fall SHALL never be high together.
REQ-021 busy SHALL be 1 exactly in the QUAL_HI and QUAL_LO states.
REQ-022 Latency SHALL be: with inpad changed before edge 0 and held, level changes after edge SYNC_STAGES+FILTER_LEN-1 and the pulse is visible in the following cycle.
REQ-023 While en=0, the sync chain SHALL keep running, QUAL_x SHALL revert to the adjacent STABLE_x state, cnt SHALL be held at 0, level SHALL hold, and no pulses SHALL be issued.
REQ-024 cnt SHALL never exceed FILTER_LEN-1 and SHALL never wrap.
REQ-025 When en rises, qualification SHALL start from cnt=0 on the first cycle with s differing from level.

Reset
REQ-026 While rst_n=0, the block SHALL asynchronously force: all sync flops=0, state=STABLE_LO, cnt=0, level=0, rise=0, fall=0, busy=0.
REQ-027 Reset asserted mid-qualification SHALL abort the qualification with no pulse; after release, the block SHALL resume from STABLE_LO.
REQ-028 Reset release SHALL be synchronous to clk; the first state update SHALL occur on the first rising edge with rst_n=1.

Verification (defaults SYNC_STAGES=2, FILTER_LEN=4)
REQ-029 The bench SHALL check: inpad 0->1 before edge 0, held, en=1 -> busy=1 after edge 2, level=1 after edge 5, rise=1 for one cycle only, fall=0 throughout.
REQ-030 The bench SHALL check: inpad high for 3 cycles then low -> busy pulses for 3 cycles, level stays 0, no rise.
REQ-031 The bench SHALL check: level=1, inpad 1->0 held -> level=0 after 6 edges, one-cycle fall, busy then 0.
REQ-032 The bench SHALL check: rst_n driven low during QUAL_HI with cnt=2 -> outputs 0 immediately without a clock, no rise after release while inpad=0.
REQ-033 The bench SHALL check: en=0, inpad toggled 0->1 held 10 cycles -> level=0, busy=0; then en=1 -> level=1 exactly 4 edges later.
REQ-034 The bench SHALL check FILTER_LEN=1: inpad 0->1 held -> level=1 after edge 2, one-cycle rise, busy never 1.
